// File: rtl/money_scan_pkg.sv
// Shared FSM encoding and BCD constants for the money_bcd_scan converter.
package money_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] BLANK_CODE     = 4'hF;
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ        = 4'd3;

endpackage

// File: rtl/bin2bcd_step.sv
// One double-dabble iteration: add 3 to nibbles >= 5, then shift in one binary bit.
module bin2bcd_step
  import money_scan_pkg::*;
#(
  parameter int DIGITS = 3
) (
  input  logic [DIGITS*4-1:0] bcd_in,
  input  logic                bit_in,
  output logic [DIGITS*4-1:0] bcd_out,
  output logic                carry
);

  logic [DIGITS*4-1:0] adj_s;

  // Adjust every nibble so the following doubling carries correctly in decimal
  always_comb begin
    adj_s = bcd_in;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_in[d*4 +: 4] >= BCD_ADJ_THRESH) begin
        adj_s[d*4 +: 4] = bcd_in[d*4 +: 4] + BCD_ADJ;
      end else begin
        adj_s[d*4 +: 4] = bcd_in[d*4 +: 4];
      end
    end
    {carry, bcd_out} = {adj_s, bit_in};
  end

endmodule

// File: rtl/money_bcd_scan.sv
// Multi-channel binary-to-BCD converter sharing one double-dabble step across channels.
// Optional build macro LEAD_ZERO_BLANK_EN blanks leading zero digits with BLANK_CODE.
module money_bcd_scan
  import money_scan_pkg::*;
#(
  parameter int VAL_W  = 8,
  parameter int DIGITS = 3,
  parameter int NCH    = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [NCH*VAL_W-1:0]    val_in,
  output logic                    ready,
  output logic                    done,
  output logic [NCH*DIGITS*4-1:0] digits,
  output logic [NCH-1:0]          ovf
);

  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CNT_W = (VAL_W > 1) ? $clog2(VAL_W) : 1;
  localparam logic [CH_W-1:0]     LAST_CH   = CH_W'(NCH - 1);
  localparam logic [CNT_W-1:0]    LAST_BIT  = CNT_W'(VAL_W - 1);
  localparam logic [DIGITS*4-1:0] ALL_NINES = {DIGITS{4'h9}};

  state_t                  state_r, next_state_s;
  logic [CH_W-1:0]         chan_idx_r;
  logic [CNT_W-1:0]        bit_cnt_r;
  logic [NCH*VAL_W-1:0]    snap_r;
  logic [VAL_W-1:0]        sreg_r;
  logic [DIGITS*4-1:0]     acc_r;
  logic                    ovf_acc_r;
  logic [NCH*DIGITS*4-1:0] stage_dig_r;
  logic [NCH-1:0]          stage_ovf_r;
  logic [NCH*DIGITS*4-1:0] disp_s;
  logic [DIGITS*4-1:0]     step_bcd_s;
  logic                    step_carry_s;
  logic                    last_bit_s;
  logic                    ch_ovf_s;

  bin2bcd_step #(.DIGITS(DIGITS)) u_step (
    .bcd_in  (acc_r),
    .bit_in  (sreg_r[VAL_W-1]),
    .bcd_out (step_bcd_s),
    .carry   (step_carry_s)
  );

  assign last_bit_s = (bit_cnt_r == LAST_BIT);
  assign ch_ovf_s   = ovf_acc_r | step_carry_s;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:  if (start) next_state_s = LOAD; else next_state_s = IDLE;
      LOAD:  next_state_s = SHIFT;
      SHIFT: begin
        if (!last_bit_s)              next_state_s = SHIFT;
        else if (chan_idx_r == LAST_CH) next_state_s = DONE;
        else                          next_state_s = LOAD;
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

`ifdef LEAD_ZERO_BLANK_EN
  // Blank leading zeros above digit 0; overflowed channels keep their nines
  always_comb begin
    logic lead;
    disp_s = stage_dig_r;
    for (int c = 0; c < NCH; c++) begin
      lead = ~stage_ovf_r[c];
      for (int d = DIGITS - 1; d > 0; d--) begin
        if (lead && (stage_dig_r[(c*DIGITS+d)*4 +: 4] == 4'h0)) begin
          disp_s[(c*DIGITS+d)*4 +: 4] = BLANK_CODE;
        end else begin
          lead = 1'b0;
        end
      end
    end
  end
`else
  // Staged digits go out unchanged
  always_comb begin
    disp_s = stage_dig_r;
  end
`endif

  // Datapath: snapshot, per-channel shift/accumulate, staging and output copy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chan_idx_r  <= '0;
      bit_cnt_r   <= '0;
      snap_r      <= '0;
      sreg_r      <= '0;
      acc_r       <= '0;
      ovf_acc_r   <= 1'b0;
      stage_dig_r <= '0;
      stage_ovf_r <= '0;
      digits      <= '0;
      ovf         <= '0;
      done        <= 1'b0;
      ready       <= 1'b1;
    end else begin
      done  <= (state_r == DONE);
      ready <= (next_state_s == IDLE);
      case (state_r)
        IDLE: begin
          if (start) begin
            snap_r     <= val_in;
            chan_idx_r <= '0;
          end
        end
        LOAD: begin
          acc_r     <= '0;
          ovf_acc_r <= 1'b0;
          bit_cnt_r <= '0;
          sreg_r    <= snap_r[chan_idx_r*VAL_W +: VAL_W];
        end
        SHIFT: begin
          acc_r     <= step_bcd_s;
          ovf_acc_r <= ch_ovf_s;
          sreg_r    <= sreg_r << 1;
          bit_cnt_r <= bit_cnt_r + CNT_W'(1);
          if (last_bit_s) begin
            stage_dig_r[chan_idx_r*DIGITS*4 +: DIGITS*4] <= ch_ovf_s ? ALL_NINES : step_bcd_s;
            stage_ovf_r[chan_idx_r] <= ch_ovf_s;
            if (chan_idx_r != LAST_CH) begin
              chan_idx_r <= chan_idx_r + CH_W'(1);
            end
          end
        end
        DONE: begin
          digits <= disp_s;
          ovf    <= stage_ovf_r;
        end
        default: begin
          chan_idx_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_money_bcd_scan.sv
// Self-checking bench: default instance plus a DIGITS=2 instance for overflow cases.
module tb_money_bcd_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start1 = 1'b0, start2 = 1'b0;
  logic [23:0] val1 = '0, val2 = '0;
  logic        ready1, ready2, done1, done2;
  logic [35:0] digits1;
  logic [23:0] digits2;
  logic [2:0]  ovf1, ovf2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  money_bcd_scan u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .val_in(val1),
    .ready(ready1), .done(done1), .digits(digits1), .ovf(ovf1)
  );

  money_bcd_scan #(.VAL_W(8), .DIGITS(2), .NCH(3)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .val_in(val2),
    .ready(ready2), .done(done2), .digits(digits2), .ovf(ovf2)
  );

  task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int pow10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // Reference: decimal digit d of val shown on an nd-digit display
  function automatic logic [3:0] ref_nib(input int val, input int nd, input int d);
    if (val >= pow10(nd)) return 4'h9;
`ifdef LEAD_ZERO_BLANK_EN
    if (d > 0 && val < pow10(d)) return 4'hF;
`endif
    return 4'((val / pow10(d)) % 10);
  endfunction

  function automatic logic [35:0] exp_dig(input int nd, input logic [23:0] v);
    logic [35:0] r = '0;
    for (int c = 0; c < 3; c++)
      for (int d = 0; d < nd; d++)
        r[(c*nd+d)*4 +: 4] = ref_nib(int'(v[c*8 +: 8]), nd, d);
    return r;
  endfunction

  function automatic logic [2:0] exp_ovf(input int nd, input logic [23:0] v);
    logic [2:0] r;
    for (int c = 0; c < 3; c++) r[c] = (int'(v[c*8 +: 8]) >= pow10(nd));
    return r;
  endfunction

  function automatic logic [35:0] cur_dig(input int sel);
    return (sel == 0) ? digits1 : {12'h0, digits2};
  endfunction

  // One conversion; restart_at>0 re-asserts start (with other data) before that edge
  task automatic run_conv(input int sel, input logic [23:0] v, input int restart_at,
                          output logic [35:0] dig, output logic [2:0] ov, output int lat);
    logic [35:0] old;
    logic held, rdy_low;
    old = cur_dig(sel);
    held = 1'b1;
    rdy_low = 1'b1;
    lat = -1;
    @(negedge clk);
    if (sel == 0) begin start1 = 1'b1; val1 = v; end
    else          begin start2 = 1'b1; val2 = v; end
    @(posedge clk);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      start1 = (sel == 0) && (k == restart_at);
      start2 = (sel == 1) && (k == restart_at);
      if (sel == 0) val1 = v ^ 24'hA5C35A; else val2 = v ^ 24'hA5C35A;
      @(posedge clk);
      #1;
      if ((sel == 0) ? done1 : done2) begin
        lat = k;
        break;
      end
      if (((sel == 0) ? ready1 : ready2) !== 1'b0) rdy_low = 1'b0;
      if (cur_dig(sel) !== old) held = 1'b0;
    end
    start1 = 1'b0;
    start2 = 1'b0;
    dig = cur_dig(sel);
    ov  = (sel == 0) ? ovf1 : ovf2;
    chk("latency", 36'(lat), 36'd28);
    chk("ready_low_busy", {35'h0, rdy_low}, 36'h1);
    chk("digits_hold", {35'h0, held}, 36'h1);
    chk("ready_at_done", {35'h0, (sel == 0) ? ready1 : ready2}, 36'h1);
    @(posedge clk);
    #1;
    chk("done_pulse_width", {35'h0, (sel == 0) ? done1 : done2}, 36'h0);
  endtask

  typedef struct {
    int          sel;
    logic [23:0] vals;
    logic [35:0] dig;
    logic [2:0]  ov;
  } vec_t;

  vec_t        tbl[6];
  logic [35:0] dig;
  logic [2:0]  ov;
  logic [23:0] v;
  int          lat;
  int          dcount;

  initial begin
`ifdef LEAD_ZERO_BLANK_EN
    tbl[0] = '{0, {8'd5,   8'd30,  8'd137}, 36'hFF5_F30_137, 3'b000};
    tbl[1] = '{0, {8'd200, 8'd0,   8'd255}, 36'h200_FF0_255, 3'b000};
    tbl[2] = '{0, {8'd0,   8'd0,   8'd0},   36'hFF0_FF0_FF0, 3'b000};
    tbl[3] = '{0, {8'd9,   8'd10,  8'd100}, 36'hFF9_F10_100, 3'b000};
    tbl[4] = '{1, {8'd100, 8'd99,  8'd150}, 36'h99_99_99,    3'b101};
    tbl[5] = '{1, {8'd10,  8'd255, 8'd5},   36'h10_99_F5,    3'b010};
`else
    tbl[0] = '{0, {8'd5,   8'd30,  8'd137}, 36'h005_030_137, 3'b000};
    tbl[1] = '{0, {8'd200, 8'd0,   8'd255}, 36'h200_000_255, 3'b000};
    tbl[2] = '{0, {8'd0,   8'd0,   8'd0},   36'h000_000_000, 3'b000};
    tbl[3] = '{0, {8'd9,   8'd10,  8'd100}, 36'h009_010_100, 3'b000};
    tbl[4] = '{1, {8'd100, 8'd99,  8'd150}, 36'h99_99_99,    3'b101};
    tbl[5] = '{1, {8'd10,  8'd255, 8'd5},   36'h10_99_05,    3'b010};
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("rst_digits", digits1, 36'h0);
    chk("rst_ovf", {33'h0, ovf1}, 36'h0);
    chk("rst_done", {35'h0, done1}, 36'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ready", {35'h0, ready1}, 36'h1);

    for (int i = 0; i < 6; i++) begin
      run_conv(tbl[i].sel, tbl[i].vals, 0, dig, ov, lat);
      chk($sformatf("tbl%0d_digits", i), dig, tbl[i].dig);
      chk($sformatf("tbl%0d_ovf", i), {33'h0, ov}, {33'h0, tbl[i].ov});
    end

    // start re-asserted while busy, and again during the DONE cycle
    for (int r = 0; r < 2; r++) begin
      v = {8'd42, 8'd7, 8'd199};
      run_conv(0, v, (r == 0) ? 10 : 28, dig, ov, lat);
      chk("restart_digits", dig, exp_dig(3, v));
      dcount = 0;
      for (int k = 0; k < 35; k++) begin
        @(posedge clk);
        #1;
        if (done1 || !ready1) dcount++;
      end
      chk("restart_ignored", 36'(dcount), 36'd0);
    end

    // Reset in the middle of a conversion
    @(negedge clk);
    start1 = 1'b1;
    val1 = {8'd77, 8'd88, 8'd99};
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    repeat (14) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_digits", digits1, 36'h0);
    chk("midrst_ovf", {33'h0, ovf1}, 36'h0);
    chk("midrst_done", {35'h0, done1}, 36'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_ready", {35'h0, ready1}, 36'h1);
    dcount = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done1) dcount++;
    end
    chk("midrst_no_done", 36'(dcount), 36'd0);
    v = {8'd250, 8'd1, 8'd64};
    run_conv(0, v, 0, dig, ov, lat);
    chk("postrst_digits", dig, exp_dig(3, v));
    chk("postrst_ovf", {33'h0, ov}, {33'h0, exp_ovf(3, v)});

    // Randomized conversions on both instances against the decimal model
    for (int i = 0; i < 24; i++) begin
      v = 24'($urandom);
      run_conv(i % 2, v, 0, dig, ov, lat);
      chk($sformatf("rand%0d_digits", i), dig, exp_dig((i % 2 == 0) ? 3 : 2, v));
      chk($sformatf("rand%0d_ovf", i), {33'h0, ov}, {33'h0, exp_ovf((i % 2 == 0) ? 3 : 2, v)});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
